// File: rtl/ring_load_driver_if.sv
// ring_load_driver_if: request and strobe bundle between a requester, the driver and its ring buffer
interface ring_load_driver_if;
  logic start;
  logic [11:0] vals;
  logic op_or;
  logic [3:0] data_out;
  logic ld_out;
  logic inc_out;
  logic busy;
  logic done;
  logic err;
  modport master(input start, vals, op_or, output data_out, ld_out, inc_out, busy, done, err);
  modport slave(output start, vals, op_or, input data_out, ld_out, inc_out, busy, done, err);
endinterface

// File: rtl/ring_load_driver.sv
// ring_load_driver: loads three nibbles into a ring buffer, then an optional OR pulse and one increment.
// Optional abort input enabled by defining RLD_ABORT_EN.
module ring_load_driver #(
  parameter int HOLD = 8,
  parameter int GAP = 4
) (
  input logic clk,
  input logic rst,
`ifdef RLD_ABORT_EN
  input logic abort,
`endif
  ring_load_driver_if.master bus
);
  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] SETUP = 4'd1;
  localparam logic [3:0] PULSE = 4'd2;
  localparam logic [3:0] GAP_W = 4'd3;
  localparam logic [3:0] OR_PULSE = 4'd4;
  localparam logic [3:0] OR_GAP = 4'd5;
  localparam logic [3:0] INC = 4'd6;
  localparam logic [3:0] INC_GAP = 4'd7;
  localparam logic [3:0] DONE = 4'd8;
  localparam logic [7:0] HOLD_C = 8'(HOLD);
  localparam logic [7:0] GAP_C = 8'(GAP);
  logic [3:0] state;
  logic [1:0] k;
  logic [7:0] cnt;
  logic [11:0] vals_q;
  logic op_q;
  logic err_q;
  logic busy;
  logic vals_ok;
  logic abort_hit;
  assign busy = state != IDLE && state != DONE;
  // a zero nibble can never complete on the receiver, so it is rejected up front
  assign vals_ok = |bus.vals[3:0] && |bus.vals[7:4] && |bus.vals[11:8];
`ifdef RLD_ABORT_EN
  assign abort_hit = abort && busy;
`else
  assign abort_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= 2'd0;
      cnt <= 8'd0;
      vals_q <= 12'd0;
      op_q <= 1'b0;
      err_q <= 1'b0;
    end else if (abort_hit) begin
      state <= IDLE;
      k <= 2'd0;
      cnt <= 8'd0;
      err_q <= 1'b1;
    end else if (busy && cnt > 8'd1) begin
      cnt <= cnt - 8'd1;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          if (vals_ok) begin
            vals_q <= bus.vals;
            op_q <= bus.op_or;
            err_q <= 1'b0;
            k <= 2'd0;
            cnt <= 8'd1;
            state <= SETUP;
          end else err_q <= 1'b1;
        end
        SETUP: begin
          state <= PULSE;
          cnt <= HOLD_C;
        end
        PULSE: begin
          state <= GAP_W;
          cnt <= GAP_C;
        end
        GAP_W: begin
          state <= k < 2'd2 ? SETUP : op_q ? OR_PULSE : INC;
          cnt <= k == 2'd2 && op_q ? HOLD_C : 8'd1;
          k <= k < 2'd2 ? k + 2'd1 : k;
        end
        OR_PULSE: begin
          state <= OR_GAP;
          cnt <= GAP_C;
        end
        OR_GAP: begin
          state <= INC;
          cnt <= 8'd1;
        end
        INC: begin
          state <= INC_GAP;
          cnt <= GAP_C;
        end
        INC_GAP: begin
          state <= DONE;
          cnt <= 8'd1;
        end
        DONE: begin
          state <= IDLE;
          cnt <= 8'd0;
          k <= 2'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    bus.data_out = !busy ? 4'd0 : k == 2'd0 ? vals_q[3:0] : k == 2'd1 ? vals_q[7:4] : vals_q[11:8];
    bus.ld_out = state == PULSE || state == OR_PULSE;
    bus.inc_out = state == INC;
    bus.busy = busy;
    bus.done = state == DONE;
    bus.err = err_q;
  end
endmodule

// File: tb/tb_ring_load_driver.sv
// tb_ring_load_driver: directed checks of load timing, rejection, restart, reset and optional abort.
module tb_ring_load_driver;
  logic clk = 1'b0;
  logic rst;
`ifdef RLD_ABORT_EN
  logic abort;
`endif
  int compared = 0;
  int mismatched = 0;
  ring_load_driver_if bus();
  ring_load_driver #(.HOLD(8), .GAP(4)) dut (
    .clk(clk),
    .rst(rst),
`ifdef RLD_ABORT_EN
    .abort(abort),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_seq(input logic op, input bit restart, input int exp_busy, input int exp_done,
                         input int exp_pulses, input logic [15:0] exp_seq);
    int busy_n = 0, done_n = 0, done_at = 0, pulses = 0, len = 0, bad_len = 0;
    int inc_n = 0, overlap = 0, viol = 0;
    logic [15:0] seq = 16'd0;
    logic pld = 1'b0;
    logic [3:0] pdata = 4'd0;
    @(negedge clk);
    bus.vals = 12'h321;
    bus.op_or = op;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      if (i > 1) @(negedge clk);
      if (restart) bus.start = (i == 10);
      if (i == 1) chk("err_clear", 32'(bus.err), 32'd0);
      busy_n += int'(bus.busy);
      if (bus.done) begin
        done_n++;
        done_at = i;
        chk("done_data", 32'(bus.data_out), 32'd0);
      end
      if (bus.ld_out && !pld) begin
        pulses++;
        seq = {seq[11:0], bus.data_out};
      end
      if (bus.ld_out) len++;
      else if (pld) begin
        if (len != 8) bad_len++;
        len = 0;
      end
      inc_n += int'(bus.inc_out);
      overlap += int'(bus.ld_out & bus.inc_out);
      if (bus.data_out != pdata && (bus.ld_out || pld)) viol++;
      pld = bus.ld_out;
      pdata = bus.data_out;
    end
    chk("busy_cycles", 32'(busy_n), 32'(exp_busy));
    chk("done_count", 32'(done_n), 32'd1);
    chk("done_cycle", 32'(done_at), 32'(exp_done));
    chk("ld_pulses", 32'(pulses), 32'(exp_pulses));
    chk("data_seq", 32'(seq), 32'(exp_seq));
    chk("ld_len", 32'(bad_len), 32'd0);
    chk("inc_count", 32'(inc_n), 32'd1);
    chk("overlap", 32'(overlap), 32'd0);
    chk("data_change_ld", 32'(viol), 32'd0);
  endtask
  initial begin
    int s;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.vals = 12'd0;
    bus.op_or = 1'b0;
`ifdef RLD_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_ld", 32'(bus.ld_out), 32'd0);
    chk("rst_inc", 32'(bus.inc_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    run_seq(1'b0, 1'b0, 44, 45, 3, 16'h0123);
    run_seq(1'b1, 1'b0, 56, 57, 4, 16'h1233);
    @(negedge clk);
    bus.vals = 12'h301;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rej_err", 32'(bus.err), 32'd1);
    chk("rej_busy", 32'(bus.busy), 32'd0);
    s = 0;
    repeat (5) begin
      @(negedge clk);
      s += int'(bus.ld_out | bus.inc_out | bus.busy);
    end
    chk("rej_quiet", 32'(s), 32'd0);
    chk("rej_sticky", 32'(bus.err), 32'd1);
    run_seq(1'b0, 1'b1, 44, 45, 3, 16'h0123);
    @(negedge clk);
    bus.vals = 12'h321;
    bus.op_or = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_ld_high", 32'(bus.ld_out), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ld", 32'(bus.ld_out), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_data", 32'(bus.data_out), 32'd0);
`ifdef RLD_ABORT_EN
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    chk("abort_ld_high", 32'(bus.ld_out), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ld", 32'(bus.ld_out), 32'd0);
    chk("abort_inc", 32'(bus.inc_out), 32'd0);
    chk("abort_data", 32'(bus.data_out), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_err", 32'(bus.err), 32'd1);
    s = int'(bus.done);
    repeat (60) begin
      @(negedge clk);
      s += int'(bus.done);
    end
    chk("abort_no_done", 32'(s), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ring_load_driver.md
RING_LOAD_DRIVER -- requirements
Module: ring_load_driver

Interface
REQ-001 SHALL have parameter HOLD, default 8: number of cycles ld_out is held high per pulse (legal range 1..255).
REQ-002 SHALL have parameter GAP, default 4: number of low cycles after each ld_out or inc_out pulse (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request a load sequence.
REQ-006 SHALL have port vals, input, 12 bits: three nibbles; entry k is vals[4k+3:4k].
REQ-007 SHALL have port op_or, input, 1 bit: select the OR reduction (1) or the AND reduction (0) on the receiving ring buffer.
REQ-008 SHALL have port data_out, output, 4 bits: nibble presented to the receiver's data input.
REQ-009 SHALL have port ld_out, output, 1 bit: load strobe to the receiver.
REQ-010 SHALL have port inc_out, output, 1 bit: increment strobe to the receiver.
REQ-011 SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1 bit: sticky flag; the last start was rejected.
REQ-014 SHALL have port abort, input, 1 bit: present only when RLD_ABORT_EN is defined.

Function
REQ-015 SHALL implement the states IDLE, SETUP, PULSE, GAP_W, OR_PULSE, OR_GAP, INC, INC_GAP and DONE.
REQ-016 In IDLE, when start=1 and all three nibbles are nonzero, SHALL latch vals and op_or, clear err, and go to SETUP with entry index 0.
REQ-017 In IDLE, when start=1 and any nibble equals 0, SHALL set err=1 and stay in IDLE; such a load can never complete on the receiver.
REQ-018 SETUP SHALL last 1 cycle with data_out = latched entry k and ld_out=0, then go to PULSE.
REQ-019 PULSE SHALL hold ld_out=1 for exactly HOLD cycles with data_out stable, then go to GAP_W.
REQ-020 GAP_W SHALL hold ld_out=0 for GAP cycles; then, if k<2, increment k and go to SETUP; if k=2, go to OR_PULSE when op_or was latched as 1, otherwise go to INC.
REQ-021 OR_PULSE/OR_GAP SHALL drive ld_out=1 for HOLD cycles, then ld_out=0 for GAP cycles, with data_out holding entry 2.
REQ-022 INC SHALL drive inc_out=1 for exactly 1 cycle; INC_GAP SHALL then hold inc_out=0 for GAP cycles.
REQ-023 DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE and DONE; start SHALL be ignored while busy=1.
REQ-025 With the start edge as cycle 0, busy SHALL be high for 3(1+HOLD+GAP) + (op_or ? HOLD+GAP : 0) + 1 + GAP cycles.
REQ-026 ld_out and inc_out SHALL never be high in the same cycle.
REQ-027 Every change of data_out SHALL occur only while ld_out=0.
REQ-028 The cycle counter SHALL be 8 bits, reload at each state entry and count down to 1; there SHALL be no wrap-around.
REQ-029 In IDLE and DONE, data_out SHALL be 0.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL enter IDLE regardless of state, clearing k, the counter, the latched vals and latched op_or.
REQ-031 After reset, data_out=0, ld_out=0, inc_out=0, busy=0, done=0 and err=0.
REQ-032 A reset asserted mid-pulse SHALL drop ld_out or inc_out on the same edge.
REQ-033 rst SHALL take priority over start and over abort.

Configuration
REQ-034 With RLD_ABORT_EN defined, abort=1 while busy SHALL force IDLE on the next edge with ld_out, inc_out and data_out low, done not pulsed, and err set.
REQ-035 Without RLD_ABORT_EN, the abort port and its logic SHALL be absent, and a started sequence SHALL always run to DONE.

Verification
REQ-036 rst=1 for 2 cycles, then 0 -> all outputs 0 and state IDLE.
REQ-037 HOLD=8, GAP=4, vals=12'h321, op_or=0, start pulse -> data_out sequence 1,2,3; three ld_out pulses of 8 cycles; one inc_out pulse; busy high 44 cycles; done at cycle 45.
REQ-038 Same stimulus with op_or=1 -> a fourth ld_out pulse of 8 cycles with data_out=3; busy high 56 cycles; done at cycle 57.
REQ-039 vals=12'h301, start -> err=1, busy stays 0, no strobes.
REQ-040 start re-pulsed at cycle 10 of a sequence -> ignored; timing identical to REQ-037.
REQ-041 rst=1 at cycle 5 of PULSE -> ld_out=0 next cycle; then with RLD_ABORT_EN, abort at cycle 20 -> IDLE, err=1, no done pulse.
